// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester picoMIPS ALU arbiter.
// Function codes must match the alucodes definitions used by the ALU itself.
package alu_arb_pkg;

  // Operand width of the shared ALU; alu_req_t is built on it.
  localparam int ALU_N = 8;

  localparam logic [1:0] RA   = 2'b00;
  localparam logic [1:0] RB   = 2'b01;
  localparam logic [1:0] RADD = 2'b10;
  localparam logic [1:0] RMUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic [1:0]       func;
  } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational: the pointer register lives
// in the parent, this block only says who wins and what the pointer becomes.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic ptr_i,
  input  logic upd_en_i,
  output logic gnt_idx_o,
  output logic gnt_vld_o,
  output logic ptr_nxt_o
);

  // A lone requester always wins; on a tie the pointer decides. After a grant
  // the pointer moves to the loser so it wins the next tie.
  always_comb begin
    gnt_vld_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      gnt_idx_o = ptr_i;
    end else begin
      gnt_idx_o = valid1_i;
    end
    ptr_nxt_o = upd_en_i ? ~gnt_idx_o : ptr_i;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one picoMIPS ALU between two requesters, round-robin, one operation
// in flight at a time. RMUL holds operands for MUL_LAT cycles, others for one.
// Optional per-requester completion counters: define ALU_ARB_STATS_EN.
//
//   state | meaning
//   IDLE  | waiting for a request; readys driven from the grant
//   EXEC  | operands held on the ALU, latency counter running down
//   DONE  | result presented on resp_*, waiting for resp_ready
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int n       = ALU_N,  // must equal ALU_N (alu_req_t width)
  parameter int MUL_LAT = 3,      // 1..15
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic [1:0]   req0_func,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic [1:0]   req1_func,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [n-1:0] resp_data,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [1:0]   alu_func,
  input  logic [n-1:0] alu_result,
  output logic         busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count0,
  output logic [CNT_W-1:0] op_count1
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         ptr_q, ptr_d;
  alu_req_t     req_q, gnt_req;
  logic         id_q;
  logic [n-1:0] resp_data_q;
  logic         gnt_idx, gnt_vld, accept, last_exec;

  assign accept    = (state_q == IDLE) && gnt_vld;
  assign last_exec = (state_q == EXEC) && (cnt_q == 4'd0);

  rr_arb2 u_rr (
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .ptr_i     (ptr_q),
    .upd_en_i  (accept),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld),
    .ptr_nxt_o (ptr_d)
  );

  // Select the winning requester's operation for capture.
  always_comb begin
    if (gnt_idx) gnt_req = '{a: req1_a, b: req1_b, func: req1_func};
    else         gnt_req = '{a: req0_a, b: req0_b, func: req0_func};
  end

  // FSM next state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = EXEC;
        cnt_d   = (gnt_req.func == RMUL) ? LAT_M1 : 4'd0;
      end
      EXEC: if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, latched request and captured result.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ptr_q       <= 1'b0;
      req_q       <= '0;
      id_q        <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        req_q <= gnt_req;
        id_q  <= gnt_idx;
      end
      if (last_exec) resp_data_q <= alu_result;
    end
  end

  assign req0_ready = accept && !gnt_idx;
  assign req1_ready = accept &&  gnt_idx;
  assign alu_a      = req_q.a;
  assign alu_b      = req_q.b;
  assign alu_func   = req_q.func;
  assign resp_valid = (state_q == DONE);
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] op_cnt0_q, op_cnt1_q;
  logic             resp_hs;

  assign resp_hs = (state_q == DONE) && resp_ready;

  // Saturating count of completed response handshakes per requester.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      op_cnt0_q <= '0;
      op_cnt1_q <= '0;
    end else if (resp_hs) begin
      if (!id_q && !(&op_cnt0_q)) op_cnt0_q <= op_cnt0_q + 1'b1;
      if ( id_q && !(&op_cnt1_q)) op_cnt1_q <= op_cnt1_q + 1'b1;
    end
  end

  assign op_count0 = op_cnt0_q;
  assign op_count1 = op_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: expected responses are queued at the
// accept handshake and compared when the response handshake happens.
module tb_alu_arbiter;

  localparam logic [1:0] F_RA = 2'b00, F_RB = 2'b01, F_RADD = 2'b10, F_RMUL = 2'b11;

  logic       clk = 1'b0;
  logic       nReset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_func, req1_func;
  logic       resp_valid, resp_ready, resp_id, busy;
  logic [7:0] resp_data, alu_a, alu_b, alu_result;
  logic [1:0] alu_func;
`ifdef ALU_ARB_STATS_EN
  logic [1:0] op_count0, op_count1;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] sb_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.n(8), .MUL_LAT(3), .CNT_W(2)) dut (
    .clk(clk), .nReset(nReset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .op_count0(op_count0), .op_count1(op_count1)
`endif
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] f);
    logic [15:0] p;
    p = a * b;
    case (f)
      F_RA:    return a;
      F_RB:    return b;
      F_RADD:  return a + b;
      default: return p[7:0];
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_func);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response side of the scoreboard plus the one-ready-at-a-time rule.
  always @(negedge clk) begin
    logic [8:0] e;
    if (req0_valid && req1_valid) check("one_ready", {31'd0, req0_ready & req1_ready}, 0);
    if (nReset && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("resp_id", {31'd0, resp_id}, {31'd0, e[8]});
        check("resp_data", {24'd0, resp_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] f);
    if (id == 0) begin req0_a = a; req0_b = b; req0_func = f; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_func = f; req1_valid = 1'b1; end
  endtask

  // Wait (bounded) for this requester's ready, complete the handshake, queue
  // the expected response, drop valid. Returns at posedge+1.
  task automatic accept(input int id, input bit push);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      return;
    end
    @(posedge clk); #1;
    if (id == 0) begin
      if (push) sb_q.push_back({1'b0, alu_model(req0_a, req0_b, req0_func)});
      req0_valid = 1'b0;
    end else begin
      if (push) sb_q.push_back({1'b1, alu_model(req1_a, req1_b, req1_func)});
      req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
  endtask

  initial begin
    int n_exec;
    bit seen;
    nReset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_func = '0;
    req1_a = '0; req1_b = '0; req1_func = '0;
    resp_ready = 1'b0;
    #3;
    check("rst_outs", {busy, resp_valid, resp_id, req0_ready, req1_ready, resp_data,
                       alu_a, alu_b, alu_func}, 0);
    @(posedge clk); #1 nReset = 1'b1;
    resp_ready = 1'b1;

    // req0 only, RADD
    @(posedge clk); #1;
    drive(0, 8'h7a, 8'h08, F_RADD);
    #1 check("t1_ready", {req0_ready, req1_ready}, 2'b10);
    accept(0, 1);
    check("t1_exec", {busy, resp_valid, alu_func}, {2'b10, F_RADD});
    check("t1_alu_a", alu_a, 8'h7a);
    @(posedge clk); #1;
    check("t1_latency", resp_valid, 1);
    check("t1_data", {resp_id, resp_data}, {1'b0, 8'h82});
    wait_idle();

    // req1 only, RMUL held MUL_LAT cycles
    drive(1, 8'h7a, 8'h08, F_RMUL);
    accept(1, 1);
    n_exec = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && !resp_valid && alu_func == F_RMUL) n_exec++;
      else break;
      @(posedge clk); #1;
    end
    check("t2_exec_cycles", n_exec, 3);
    check("t2_resp", {resp_valid, resp_id, resp_data}, {2'b11, 8'hd0});
    wait_idle();

    // Simultaneous requests, pointer at 0
    drive(0, 8'h11, 8'h00, F_RA);
    drive(1, 8'h00, 8'h22, F_RB);
    #1 check("t3_ready_first", {req0_ready, req1_ready}, 2'b10);
    accept(0, 1);
    accept(1, 1);
    wait_idle();
    drive(0, 8'h33, 8'h44, F_RADD);
    drive(1, 8'h55, 8'h66, F_RADD);
    #1 check("t3_ready_again", {req0_ready, req1_ready}, 2'b10);
    accept(0, 1);
    accept(1, 1);
    wait_idle();

    // Backpressure in DONE
    resp_ready = 1'b0;
    drive(0, 8'h01, 8'h02, F_RADD);
    accept(0, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (resp_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("t4_resp_seen", seen, 1);
    drive(1, 8'h55, 8'h00, F_RA);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold", {resp_valid, resp_id, resp_data, req0_ready, req1_ready},
            {2'b10, 8'h03, 2'b00});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_idle", {busy, req1_ready}, 2'b01);
    accept(1, 1);
    wait_idle();

    // Reset during 2nd EXEC cycle of RMUL
    drive(0, 8'h7a, 8'h08, F_RMUL);
    accept(0, 0);
    @(posedge clk); #1;
    check("t5_in_exec", {busy, resp_valid}, 2'b10);
    nReset = 1'b0;
    #1;
    check("t5_rst_outs", {busy, resp_valid, resp_id, req0_ready, req1_ready, resp_data,
                          alu_a, alu_b, alu_func}, 0);
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("t5_no_resp", seen, 0);
    drive(1, 8'h05, 8'h06, F_RADD);
    accept(1, 1);
    wait_idle();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    check("t6_cnt_rst", {op_count0, op_count1}, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'(i), 8'h01, F_RADD);
      accept(0, 1);
      wait_idle();
      if (i == 1) check("t6_cnt_two", {op_count0, op_count1}, 4'b1000);
    end
    check("t6_cnt_sat", {op_count0, op_count1}, 4'b1100);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single picoMIPS ALU between two requesters, e.g. the instruction datapath and a coprocessor/debug port.
- Arbitrates round-robin and drives the ALU operand and function inputs from a latched request.
- Holds each operation for a function-dependent number of cycles: multiply is multi-cycle, all other functions take one cycle.
- Returns the captured result on a single response channel tagged with the requester ID.

Parameters:
- n, 8, data width of operands and result (matches ALU n).
- MUL_LAT, 3, cycles the operands are held for RMUL before result capture; legal range 1..15.
- CNT_W, 16, width of the optional operation counters.

Ports:
- clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  n  requester 0 operands.
- req0_func  in  2  requester 0 ALU function (RADD/RMUL/RA/RB codes).
- req1_valid, req1_ready, req1_a, req1_b, req1_func: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  requester that issued the result.
- resp_data  out  n  captured ALU result.
- alu_a, alu_b  out  n  to ALU a/b.
- alu_func  out  2  to ALU ALUfunc.
- alu_result  in  n  from ALU result (combinational).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the next edge):
  - state=IDLE; rr pointer=0 (requester 0 has priority).
  - All outputs 0, including alu_a, alu_b, alu_func, resp_*, readys and busy.
  - Asserting reset mid-operation aborts it: no response is produced and the latched request is lost.
- FSM states:
  - IDLE -> EXEC when any reqX_valid is sampled high.
  - EXEC -> DONE when the cycle counter reaches zero.
  - DONE -> IDLE when resp_ready is high while resp_valid is high.
- Grant (IDLE):
  - If only one requester is valid, grant it.
  - If both are valid, grant the one selected by the rr pointer.
  - reqX_ready = (state==IDLE) && grant==X. It is combinational from valid and pointer, and high for at most one requester.
  - Handshake completes when ready and valid are both high. In that cycle the operands, func and id are registered; the pointer is set to the non-granted requester.
- EXEC:
  - alu_a, alu_b, alu_func are driven from registers and stay stable for the whole of EXEC.
  - Counter loads MUL_LAT-1 for RMUL and 0 otherwise, so EXEC lasts MUL_LAT cycles for RMUL and 1 cycle for all other functions.
  - On the last EXEC cycle, alu_result is captured into resp_data; resp_valid rises on the next edge.
- DONE:
  - resp_valid=1; resp_data and resp_id are held stable until the handshake completes.
  - No new request is accepted, so both readys are 0.
- Latency: accept edge to resp_valid is 1 cycle for RADD/RA/RB and MUL_LAT cycles for RMUL. Minimum turnaround is one accepted operation per 3 cycles (IDLE, EXEC, DONE).
- After the response handshake, the ALU outputs hold their last values; they are not re-zeroed.
- Width: no arithmetic is performed in the arbiter. The result is exactly the n-bit ALU output.
- A requester that drops valid before ready is seen high is not served; no state change results.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs op_count0 and op_count1, each CNT_W bits.
  - Each counts completed response handshakes for its requester and saturates at all-ones.
  - Both reset to 0.
- Undefined:
  - Ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg holds:
  - the state enum (IDLE, EXEC, DONE);
  - typedef alu_req_t {a, b, func};
  - the function codes as localparams, identical in value to the alucodes definitions.
- One sub-module, rr_arb2: 2-way round-robin grant. Inputs are the two valids, the pointer and an update enable; outputs are grant index and grant valid.

Test Plan:
- req0 only, a=8'h7a, b=8'h08, RADD -> req0_ready for 1 cycle; EXEC 1 cycle; resp_valid next edge with resp_data=8'h82, resp_id=0.
- req1 only, same operands, RMUL, MUL_LAT=3 -> alu_func=RMUL held 3 cycles; resp_data equals the bench ALU model for (7a,08,RMUL); resp_id=1.
- Both valid after reset (req0 RA a=8'h11, req1 RB b=8'h22) -> req0 served first (data 8'h11), then req1 (data 8'h22). Next simultaneous pair -> requester 0 again, since the pointer went back to 0 after serving req1.
- resp_ready held low 5 cycles in DONE -> resp_valid, resp_data and resp_id stable; both readys 0; IDLE entered one cycle after resp_ready rises.
- nReset pulled low on the 2nd EXEC cycle of RMUL -> all outputs 0 immediately; no resp_valid after release; a new request is accepted normally.
- With ALU_ARB_STATS_EN defined and CNT_W=2: 4 completed req0 operations -> op_count0 saturates at 2'b11, op_count1=0.
